// File: rtl/speck_cmd_framer.sv
// Command framer for the SPECK64/128 UART bridge: decodes K/E/D commands,
// assembles key and block frames, drives the core and serialises the result.
module speck_cmd_framer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic [127:0] o_key_out,
  output logic         o_key_load,
  input  logic         i_key_ready,
  output logic [63:0]  o_blk_out,
  output logic         o_blk_decrypt,
  output logic         o_blk_start,
  input  logic         i_core_done,
  input  logic [63:0]  i_core_result,
  output logic         o_busy,
  output logic         o_cmd_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h45;
  localparam logic [7:0] CMD_DEC = 8'h44;

  typedef enum logic [2:0] {
    IDLE, RX_KEY, RX_BLK, KEY_START, KEY_WAIT, CORE_START, CORE_WAIT, TX
  } state_t;

  state_t          r_state;
  logic [3:0]      r_byte_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [2:0]      r_tx_idx;
  logic [63:0]     r_shift;
  logic            r_key_valid;
  logic [127:0]    r_key;
  logic [63:0]     r_blk;
  logic            r_blk_decrypt;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic            r_key_load;
  logic            r_blk_start;
  logic            r_busy;
  logic            r_cmd_err;

  logic w_tmo_hit;
  logic w_overrun;

  assign w_tmo_hit = (r_tmo_cnt == TMO_MAX);
  // Bytes arriving while the framer is not collecting a frame are dropped.
  assign w_overrun = i_rx_valid && (r_state != IDLE) &&
                     (r_state != RX_KEY) && (r_state != RX_BLK);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_byte_cnt    <= '0;
      r_tmo_cnt     <= '0;
      r_tx_idx      <= '0;
      r_shift       <= '0;
      r_key_valid   <= 1'b0;
      r_key         <= '0;
      r_blk         <= '0;
      r_blk_decrypt <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_key_load    <= 1'b0;
      r_blk_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_key_load  <= 1'b0;
      r_blk_start <= 1'b0;
      r_cmd_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_rx_valid) begin
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
            if (i_rx_data == CMD_KEY) begin
              r_state <= RX_KEY;
              r_busy  <= 1'b1;
            end else if (i_rx_data == CMD_ENC || i_rx_data == CMD_DEC) begin
              r_state       <= RX_BLK;
              r_busy        <= 1'b1;
              r_blk_decrypt <= (i_rx_data == CMD_DEC);
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        RX_KEY: begin
          if (i_rx_valid) begin
            r_key[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
            r_byte_cnt <= r_byte_cnt + 4'd1;
            r_tmo_cnt  <= '0;
            if (r_byte_cnt == 4'd0) r_key_valid <= 1'b0;
            if (r_byte_cnt == 4'd15) begin
              r_state    <= KEY_START;
              r_key_load <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_cmd_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        RX_BLK: begin
          if (i_rx_valid) begin
            r_blk[{r_byte_cnt[2:0], 3'b000} +: 8] <= i_rx_data;
            r_byte_cnt <= r_byte_cnt + 4'd1;
            r_tmo_cnt  <= '0;
            // The start pulse is only issued when a key schedule is available.
            if (r_byte_cnt == 4'd7) begin
              r_state     <= CORE_START;
              r_blk_start <= r_key_valid;
            end
          end else if (w_tmo_hit) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_cmd_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        KEY_START: r_state <= KEY_WAIT;
        KEY_WAIT: begin
          if (i_key_ready) begin
            r_key_valid <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        CORE_START: begin
          if (!r_key_valid) begin
            r_cmd_err <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_state <= CORE_WAIT;
          end
        end
        CORE_WAIT: begin
          if (i_core_done) begin
            r_shift    <= i_core_result;
            r_tx_data  <= i_core_result[7:0];
            r_tx_valid <= 1'b1;
            r_tx_idx   <= '0;
            r_state    <= TX;
          end
        end
        TX: begin
          if (r_tx_valid && i_tx_ready) begin
            if (r_tx_idx == 3'd7) begin
              r_tx_valid <= 1'b0;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_tx_idx  <= r_tx_idx + 3'd1;
              r_tx_data <= r_shift[15:8];
              r_shift   <= {8'h00, r_shift[63:8]};
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_overrun) r_cmd_err <= 1'b1;
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = r_tx_valid;
  assign o_key_out     = r_key;
  assign o_key_load    = r_key_load;
  assign o_blk_out     = r_blk;
  assign o_blk_decrypt = r_blk_decrypt;
  assign o_blk_start   = r_blk_start;
  assign o_busy        = r_busy;
  assign o_cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_speck_cmd_framer.sv
// Scoreboard bench for speck_cmd_framer with behavioural key-schedule/core
// responders and a SPECK64/128 reference model.
module tb_speck_cmd_framer;

  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rxData;
  logic         rxValid;
  logic [7:0]   txData;
  logic         txValid;
  logic         txReady;
  logic [127:0] keyOut;
  logic         keyLoad;
  logic         keyReady;
  logic [63:0]  blkOut;
  logic         blkDecrypt;
  logic         blkStart;
  logic         coreDone;
  logic [63:0]  coreResult;
  logic         busy;
  logic         cmdErr;

  speck_cmd_framer #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rxData), .i_rx_valid(rxValid),
    .o_tx_data(txData), .o_tx_valid(txValid), .i_tx_ready(txReady),
    .o_key_out(keyOut), .o_key_load(keyLoad), .i_key_ready(keyReady),
    .o_blk_out(blkOut), .o_blk_decrypt(blkDecrypt), .o_blk_start(blkStart),
    .i_core_done(coreDone), .i_core_result(coreResult),
    .o_busy(busy), .o_cmd_err(cmdErr)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int lastRxEdge = 0;

  logic [127:0] expKeyQ[$];
  logic [64:0]  expBlkQ[$];
  logic [7:0]   expTxQ[$];
  int           expErr = 0;

  logic [127:0] modelKey = '0;
  bit           modelKeyValid = 1'b0;

  bit randReady = 1'b0;
  bit stallReq  = 1'b0;
  int stallLen  = 20;
  int stallCnt  = 0;
  int txCount   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // SPECK64/128 straight from the cipher definition: 27 rounds, alpha 8, beta 3.
  function automatic logic [63:0] speckRef(input logic [127:0] key, input logic [63:0] blk, input bit dec);
    logic [31:0] k [0:26];
    logic [31:0] l [0:29];
    logic [31:0] x, y;
    k[0] = key[31:0];
    l[0] = key[63:32];
    l[1] = key[95:64];
    l[2] = key[127:96];
    for (int i = 0; i < 26; i++) begin
      l[i+3] = (k[i] + {l[i][7:0], l[i][31:8]}) ^ 32'(i);
      k[i+1] = {k[i][28:0], k[i][31:29]} ^ l[i+3];
    end
    x = blk[63:32];
    y = blk[31:0];
    if (!dec) begin
      for (int i = 0; i < 27; i++) begin
        x = ({x[7:0], x[31:8]} + y) ^ k[i];
        y = {y[28:0], y[31:29]} ^ x;
      end
    end else begin
      for (int i = 26; i >= 0; i--) begin
        y = y ^ x;
        y = {y[2:0], y[31:3]};
        x = (x ^ k[i]) - y;
        x = {x[23:0], x[31:24]};
      end
    end
    return {x, y};
  endfunction

  // Key schedule responder: key_ready drops on key_load and returns later.
  initial begin
    keyReady = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && keyLoad) begin
        keyReady = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        keyReady = 1'b1;
      end
    end
  end

  // Core responder computes its answer from whatever the framer presents.
  logic [63:0] coreCalc;
  initial begin
    coreDone = 1'b0;
    coreResult = '0;
    forever begin
      @(negedge clk);
      if (rst_n && blkStart) begin
        coreCalc = speckRef(keyOut, blkOut, blkDecrypt);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        coreDone = 1'b1;
        coreResult = coreCalc;
        @(negedge clk);
        coreDone = 1'b0;
        coreResult = '0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (stallCnt > 0) begin
      txReady = 1'b0;
      stallCnt--;
    end else if (stallReq && txCount == 4) begin
      txReady = 1'b0;
      stallCnt = stallLen - 1;
      stallReq = 1'b0;
    end else begin
      txReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  bit prevStall = 1'b0;
  bit idleCheckPending = 1'b0;
  logic [7:0] heldData;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
      idleCheckPending = 1'b0;
    end else begin
      if (idleCheckPending) begin
        idleCheckPending = 1'b0;
        checkOutput("idle_after_last_tx", {busy, txValid}, 0);
      end
      if (prevStall) begin
        checkOutput("tx_hold_valid", txValid, 1);
        checkOutput("tx_hold_data", txData, heldData);
      end
      if (keyLoad) begin
        if (expKeyQ.size() == 0) checkOutput("key_load_spurious", keyLoad, 0);
        else begin
          checkOutput("key_out", keyOut, expKeyQ.pop_front());
          checkOutput("key_load_latency", cyc, lastRxEdge);
        end
      end
      if (blkStart) begin
        txCount = 0;
        if (expBlkQ.size() == 0) checkOutput("blk_start_spurious", blkStart, 0);
        else begin
          logic [64:0] e;
          e = expBlkQ.pop_front();
          checkOutput("blk_out", blkOut, e[63:0]);
          checkOutput("blk_decrypt", blkDecrypt, e[64]);
          checkOutput("blk_start_latency", cyc, lastRxEdge);
        end
      end
      if (cmdErr) begin
        if (expErr > 0) expErr--;
        else checkOutput("cmd_err_spurious", cmdErr, 0);
      end
      if (txValid && txReady) begin
        if (expTxQ.size() == 0) checkOutput("tx_spurious", txValid, 0);
        else checkOutput("tx_byte", txData, expTxQ.pop_front());
        txCount++;
        if (txCount == 8) idleCheckPending = 1'b1;
      end
      prevStall = txValid && !txReady;
      heldData = txData;
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit isCmd);
    @(posedge clk);
    #1;
    rxData = b;
    rxValid = 1'b1;
    @(posedge clk);
    #1;
    rxValid = 1'b0;
    rxData = 8'($urandom);
    lastRxEdge = cyc;
    if (isCmd) checkOutput("busy_after_cmd", busy, 1);
  endtask

  // Queues the model's expectations for a complete frame, then sends it.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [127:0] payload, input int gapMax,
                               input bit useConst, input logic [63:0] constRes);
    int n;
    bit errFrame;
    logic [63:0] res;
    n = (cmd == 8'h4B) ? 16 : 8;
    errFrame = 1'b0;
    if (cmd == 8'h4B) begin
      expKeyQ.push_back(payload);
      modelKey = payload;
      modelKeyValid = 1'b1;
    end else if (modelKeyValid) begin
      expBlkQ.push_back({cmd == 8'h44, payload[63:0]});
      res = useConst ? constRes : speckRef(modelKey, payload[63:0], cmd == 8'h44);
      for (int i = 0; i < 8; i++) expTxQ.push_back(res[8*i +: 8]);
    end else begin
      errFrame = 1'b1;
    end
    sendByte(cmd, 1'b1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapMax)) @(posedge clk);
      sendByte(payload[8*i +: 8], 1'b0);
    end
    if (errFrame) expErr++;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (!(busy == 1'b0 && expErr == 0 && expTxQ.size() == 0 && expKeyQ.size() == 0 &&
             expBlkQ.size() == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL idle_wait: busy=%0d pendingTx=%0d pendingErr=%0d pendingKey=%0d pendingBlk=%0d required all zero",
               busy, expTxQ.size(), expErr, expKeyQ.size(), expBlkQ.size());
    end
    @(negedge clk);
  endtask

  task automatic waitStall();
    int n;
    n = 0;
    while (stallCnt == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL stall_wait: tx byte 4 never presented (txCount=%0d required 4)", txCount);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] p;
    int r;
    rst_n = 1'b0;
    rxData = 8'h00;
    rxValid = 1'b0;
    txReady = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_valid", txValid, 0);
    checkOutput("rst_tx_data", txData, 0);
    checkOutput("rst_key_load", keyLoad, 0);
    checkOutput("rst_blk_start", blkStart, 0);
    checkOutput("rst_cmd_err", cmdErr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_blk_decrypt", blkDecrypt, 0);
    checkOutput("rst_key_out", keyOut, 0);
    checkOutput("rst_blk_out", blkOut, 0);
    rst_n = 1'b1;

    // Encrypt before any key: error, no core access.
    applyStimulus(8'h45, 128'h3b7265747475432d, 2, 1'b0, 64'h0);
    waitIdle(200);

    applyStimulus(8'h4B, 128'h1b1a1918_13121110_0b0a0908_03020100, 2, 1'b0, 64'h0);
    waitIdle(200);
    checkOutput("busy_after_key", busy, 0);

    applyStimulus(8'h45, 128'h3b7265747475432d, 2, 1'b1, 64'h8c6fa548454e028b);
    waitIdle(300);

    // Decrypt with a 20-cycle transmit stall after byte 3 and an overrun byte.
    stallLen = 20;
    stallReq = 1'b1;
    applyStimulus(8'h44, 128'h8c6fa548454e028b, 2, 1'b1, 64'h3b7265747475432d);
    waitStall();
    expErr++;
    sendByte(8'h33, 1'b0);
    checkOutput("busy_during_stall", busy, 1);
    waitIdle(300);

    expErr++;
    sendByte(8'h5A, 1'b0);
    checkOutput("busy_after_bad_cmd", busy, 0);
    waitIdle(50);

    // Partial frame followed by silence must time out.
    sendByte(8'h45, 1'b1);
    for (int i = 0; i < 3; i++) sendByte(8'($urandom), 1'b0);
    expErr++;
    waitIdle(TMO * 4);
    checkOutput("busy_after_timeout", busy, 0);
    applyStimulus(8'h45, {64'h0, $urandom, $urandom}, 3, 1'b0, 64'h0);
    waitIdle(300);

    randReady = 1'b1;
    for (int f = 0; f < 25; f++) begin
      r = $urandom_range(0, 3);
      p = {$urandom, $urandom, $urandom, $urandom};
      if (r == 0) applyStimulus(8'h4B, p, 4, 1'b0, 64'h0);
      else if (r == 3) applyStimulus(8'h44, {64'h0, p[63:0]}, 4, 1'b0, 64'h0);
      else applyStimulus(8'h45, {64'h0, p[63:0]}, 4, 1'b0, 64'h0);
      waitIdle(400);
    end
    randReady = 1'b0;

    // Reset while byte 4 of the response is on the transmit port.
    stallLen = 500;
    stallReq = 1'b1;
    applyStimulus(8'h45, {64'h0, $urandom, $urandom}, 2, 1'b0, 64'h0);
    waitStall();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_tx_valid", txValid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_tx_data", txData, 0);
    checkOutput("abort_key_out", keyOut, 0);
    checkOutput("abort_blk_out", blkOut, 0);
    checkOutput("abort_blk_decrypt", blkDecrypt, 0);
    expTxQ.delete();
    stallCnt = 0;
    stallReq = 1'b0;
    modelKeyValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h45, {64'h0, $urandom, $urandom}, 2, 1'b0, 64'h0);
    waitIdle(200);

    checkOutput("final_tx_queue", expTxQ.size(), 0);
    checkOutput("final_err_pending", expErr, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
